muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS EXE stage, next to the ALU and fed by the same forwarded operand pair. It executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers and handles MTHI/MTLO. It exposes `busy` so the hazard unit can stall dependent MFHI/MFLO and further mul/div issue.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_div_restore_step.sv | 19 +
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit: operation
// encodings (kept alongside the EXE_ALU_* codes) and small op-decode helpers.
package muldiv_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_restore_step.sv
// One combinational restoring-divide step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not borrow.
module div_restore_step
  import muldiv_unit_pkg::*;
(
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] divisor,
  input  logic              dvd_bit,
  output logic [DATA_W:0]   rem_out,
  output logic              q_bit
);

  logic [DATA_W+1:0] diff;

  assign diff    = {rem_in, dvd_bit} - {2'b00, divisor};
  assign q_bit   = ~diff[DATA_W+1];
  assign rem_out = q_bit ? diff[DATA_W:0] : {rem_in[DATA_W-1:0], dvd_bit};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        oper,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e                state, state_nxt;
  logic [4:0]            cnt;
  logic                  op_div, neg_q, neg_r, div_zero;
  logic [DATA_W-1:0]     opnd;
  logic [2*DATA_W-1:0]   acc;
  logic [DATA_W:0]       rem, rem_nxt;
  logic                  q_bit;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W-1:0]     mag_a, mag_b, res_q, res_r;
  logic [2*DATA_W-1:0]   res_p;
  logic                  issue, issue_md;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn_op);
    return (sgn_op && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign busy     = (state != S_IDLE);
  assign issue    = (state == S_IDLE) && start && !cancel;
  assign issue_md = issue && is_muldiv(oper);

  assign mag_a = magnitude(a, is_signed_op(oper));
  assign mag_b = magnitude(b, is_signed_op(oper));

  div_restore_step u_step (
    .rem_in  (rem),
    .divisor (opnd),
    .dvd_bit (acc[DATA_W-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Upper half of the accumulator plus carry; low half holds unconsumed multiplier bits.
  assign mul_sum = acc[0] ? ({1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd})
                          :  {1'b0, acc[2*DATA_W-1:DATA_W]};

  assign res_q = div_zero ? '1 : cond_neg32(acc[DATA_W-1:0], neg_q);
  assign res_r = cond_neg32(rem[DATA_W-1:0], neg_r);
  assign res_p = cond_neg64(acc, neg_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (issue_md) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = is_mul(oper) ? S_FIX : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (cancel)               state_nxt = S_IDLE;
        else if (cnt == 5'd31)    state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_FIX) && !cancel;
      if (issue_md || cancel)   cnt <= '0;
      else if (state == S_CALC) cnt <= cnt + 5'd1;
      if (issue && oper == MD_MTHI) hi <= a;
      if (issue && oper == MD_MTLO) lo <= a;
      if (state == S_FIX && !cancel) begin
        if (op_div) {hi, lo} <= {res_r, res_q};
        else        {hi, lo} <= res_p;
      end
    end
  end

  // Operand/accumulator datapath: loaded on issue, stepped once per CALC cycle.
  always_ff @(posedge clk) begin
    if (issue_md) begin
      op_div   <= !is_mul(oper);
      neg_q    <= is_signed_op(oper) && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r    <= is_signed_op(oper) && a[DATA_W-1];
      div_zero <= (b == '0);
      rem      <= '0;
      if (is_mul(oper)) begin
`ifdef MULDIV_FAST_MUL_EN
        acc <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`else
        acc <= {{DATA_W{1'b0}}, mag_b};
`endif
        opnd <= mag_a;
      end else begin
        acc  <= {{DATA_W{1'b0}}, mag_a};
        opnd <= mag_b;
      end
    end else if (state == S_CALC) begin
      if (op_div) begin
        rem               <= rem_nxt;
        acc[DATA_W-1:0]   <= {acc[DATA_W-2:0], q_bit};
      end else begin
        acc <= {mul_sum, acc[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed ops checked against
// a plain-arithmetic reference model; a monitor pops expectations on each done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  oper = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    longint q, r;
    logic [63:0] p;
    case (op)
      MD_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      MD_MULTU: return {32'b0, x} * {32'b0, y};
      MD_DIV: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
    return (op == MD_MULT || op == MD_MULTU) ? 1 : 33;
`else
    return (op == MD_MULT || op == MD_MULTU) ? 33 : 33;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi", {32'b0, hi}, {32'b0, mon_e[63:32]});
        chk("result_lo", {32'b0, lo}, {32'b0, mon_e[31:0]});
      end
    end
  end

  task automatic do_start(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; oper = op; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int expn);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, n, expn);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    if (is_muldiv(op)) begin
      e = ref_model(op, x, y);
      exp_q.push_back(e);
      {hi_m, lo_m} = e;
      do_start(op, x, y);
      chk("busy_on_issue", busy, 1);
      wait_idle("busy_cycles", exp_busy(op));
    end else begin
      if (op == MD_MTHI) hi_m = x;
      else lo_m = x;
      do_start(op, x, y);
      chk("mt_busy", busy, 0);
      chk("mt_hi", hi, hi_m);
      chk("mt_lo", lo, lo_m);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] cop;
    #3;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("multu_hi_const", hi, 32'hFFFFFFFE);
    chk("multu_lo_const", lo, 32'h00000001);
    chk("multu_done", done, 1);
    run_op(MD_MULT, -32'sd3, 32'sd7);
    @(negedge clk);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFEB);
    run_op(MD_DIV, -32'sd7, 32'sd2);
    @(negedge clk);
    chk("div_lo_const", lo, 32'hFFFFFFFD);
    chk("div_hi_const", hi, 32'hFFFFFFFF);
    run_op(MD_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    chk("divu0_lo_const", lo, 32'hFFFFFFFF);
    chk("divu0_hi_const", hi, 32'd7);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk);
    chk("ovf_lo_const", lo, 32'h80000000);
    chk("ovf_hi_const", hi, 32'h0);
    run_op(MD_DIV, -32'sd7, 32'd0);

    // second start during busy must be ignored
    {hi_m, lo_m} = ref_model(MD_DIVU, 32'd1000, 32'd7);
    exp_q.push_back({hi_m, lo_m});
    do_start(MD_DIVU, 32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    do_start(MD_DIVU, 32'd5, 32'd2);
    wait_idle("ignored_start_busy", 29);

    // cancel mid-operation
    run_op(MD_MTHI, 32'h12345678, 32'd0);
`ifdef MULDIV_FAST_MUL_EN
    cop = MD_DIVU;
`else
    cop = MD_MULT;
`endif
    do_start(cop, 32'd2, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_hi", hi, 32'h12345678);
    chk("cancel_lo", lo, lo_m);
    @(negedge clk);
    chk("cancel_done", done, 0);
    repeat (2) @(negedge clk);

    // cancel together with start in IDLE
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; oper = MD_MTLO; a = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", busy, 0);
    chk("cancel_start_lo", lo, lo_m);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 5)), pick(), pick());
    end

    // async reset mid-operation
    do_start(MD_DIVU, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    do_start(MD_DIVU, 32'd9, 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    hi_m = '0; lo_m = '0;
    @(negedge clk) rst_n = 1'b1;
    run_op(MD_MULTU, 32'd6, 32'd7);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
